// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock session sequencer and pinCodeTester.
package lock_pkg;

  // Session states; all four 2-bit codes are used.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VERIFY  = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  // Keypad strobe value meaning "no key this cycle".
  localparam logic [3:0] KEY_NONE = 4'h0;

  // Digits per attempt; pinCodeTester must be built with the same value.
  localparam int DEFAULT_DIGITS = 4;

endpackage

// File: rtl/lock_down_counter.sv
// Loadable down-counter that stops at zero; used for window, hold and lockout timing.
module lock_down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero
);

  // Clear wins over load, load wins over decrement; decrement holds at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lockout_controller.sv
// Session sequencer in front of pinCodeTester: gates keypad strobes, classifies
// attempts from the tester's unlock pulse, holds the door open and enforces lockout.
module lockout_controller
  import lock_pkg::*;
#(
  parameter int DIGITS         = DEFAULT_DIGITS,
  parameter int RESULT_WINDOW  = 8,
  parameter int HOLD_CYCLES    = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [3:0]                        keyIn,
  input  logic                              testerUnlock,
  output logic [3:0]                        keyOut,
  output logic                              unlocked,
  output logic                              lockedOut,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] failCount,
  output logic                              busy
);

  localparam int DIG_W  = $clog2(DIGITS + 1);
  localparam int WIN_W  = $clog2(RESULT_WINDOW + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FC_W   = $clog2(MAX_ATTEMPTS + 1);

  lock_state_t       state;
  lock_state_t       stateNext;
  logic [DIG_W-1:0]  digitCount;
  logic [DIG_W-1:0]  digitNext;
  logic [FC_W-1:0]   failNext;
  logic [3:0]        keyNext;

  logic [WIN_W-1:0]  windowCount;
  logic [HOLD_W-1:0] holdCount;
  logic [LOCK_W-1:0] lockCount;
  logic              windowZero;
  logic              holdZero;
  logic              lockZero;

  logic windowLoad;
  logic windowEn;
  logic holdLoad;
  logic holdEn;
  logic lockLoad;
  logic lockEn;
  logic counterClear;

  logic keyValid;
  logic lastDigit;
  logic windowLast;
  logic holdLast;
  logic lockLast;
  logic failLocks;

  // Failure count plus one, pinned at MAX_ATTEMPTS so it can never wrap.
  function automatic logic [FC_W-1:0] sat_inc(input logic [FC_W-1:0] v);
    logic [FC_W-1:0] r;
    if ((int'(v) + 1) >= MAX_ATTEMPTS) begin
      r = FC_W'(MAX_ATTEMPTS);
    end else begin
      r = v + FC_W'(1);
    end
    return r;
  endfunction

  assign keyValid  = (keyIn != KEY_NONE);
  assign lastDigit = (int'(digitCount) == (DIGITS - 1));
  assign failLocks = ((int'(failCount) + 1) >= MAX_ATTEMPTS);

  // A counter loaded with N marks its N-th (final) cycle when it reads 1;
  // zero is treated the same so a stray zero never stalls a state.
  assign windowLast = windowZero || (windowCount == WIN_W'(1));
  assign holdLast   = holdZero   || (holdCount   == HOLD_W'(1));
  assign lockLast   = lockZero   || (lockCount   == LOCK_W'(1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Registered key forwarding, digit count and consecutive-failure count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keyOut     <= KEY_NONE;
      digitCount <= '0;
      failCount  <= '0;
    end else begin
      keyOut     <= keyNext;
      digitCount <= digitNext;
      failCount  <= failNext;
    end
  end

  // Next-state, digit-count and failure-count decisions.
  always_comb begin
    stateNext = state;
    digitNext = digitCount;
    failNext  = failCount;
    case (state)
      IDLE: begin
        if (keyValid) begin
          if (lastDigit) begin
            stateNext = VERIFY;
            digitNext = '0;
          end else begin
            digitNext = digitCount + DIG_W'(1);
          end
        end
      end
      VERIFY: begin
        if (testerUnlock) begin
          stateNext = OPEN;
          failNext  = '0;
        end else if (windowLast) begin
          failNext  = sat_inc(failCount);
          stateNext = failLocks ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
        if (holdLast) begin
          stateNext = IDLE;
        end
      end
      LOCKOUT: begin
        if (lockLast) begin
          stateNext = IDLE;
          failNext  = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        digitNext = '0;
        failNext  = '0;
      end
    endcase
  end

  // Moore outputs, key gating and timer control for the current state.
  always_comb begin
    keyNext      = KEY_NONE;
    unlocked     = 1'b0;
    lockedOut    = 1'b0;
    busy         = 1'b1;
    windowLoad   = 1'b0;
    windowEn     = 1'b0;
    holdLoad     = 1'b0;
    holdEn       = 1'b0;
    lockLoad     = 1'b0;
    lockEn       = 1'b0;
    counterClear = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        keyNext    = keyIn;
        windowLoad = keyValid && lastDigit;
      end
      VERIFY: begin
        windowEn = 1'b1;
        holdLoad = testerUnlock;
        lockLoad = !testerUnlock && windowLast && failLocks;
      end
      OPEN: begin
        unlocked = 1'b1;
        holdEn   = 1'b1;
      end
      LOCKOUT: begin
        lockedOut = 1'b1;
        lockEn    = 1'b1;
      end
      default: begin
        busy         = 1'b0;
        counterClear = 1'b1;
      end
    endcase
  end

  lock_down_counter #(.W(WIN_W)) u_window (
    .clock     (clock),
    .reset     (reset),
    .clear     (counterClear),
    .load      (windowLoad),
    .loadValue (WIN_W'(RESULT_WINDOW)),
    .enable    (windowEn),
    .count     (windowCount),
    .zero      (windowZero)
  );

  lock_down_counter #(.W(HOLD_W)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .clear     (counterClear),
    .load      (holdLoad),
    .loadValue (HOLD_W'(HOLD_CYCLES)),
    .enable    (holdEn),
    .count     (holdCount),
    .zero      (holdZero)
  );

  lock_down_counter #(.W(LOCK_W)) u_lock (
    .clock     (clock),
    .reset     (reset),
    .clear     (counterClear),
    .load      (lockLoad),
    .loadValue (LOCK_W'(LOCKOUT_CYCLES)),
    .enable    (lockEn),
    .count     (lockCount),
    .zero      (lockZero)
  );

endmodule
